n64_bit_receiver: RTL and testbench
===================================

Name: n64_bit_receiver

Overview:
Receives and decodes the N64 controller's response on the single-wire data line, the opposite direction from the per-bit send state machines. A 1 bit is 1 us low then 3 us high; a 0 bit is 3 us low then 1 us high. After an armed request, the block measures each low pulse and shifts NUM_BITS decoded bits into a word. It then checks the stop bit and hands the word to the button-decode logic with a one-cycle Valid pulse.

Parameters:
CYCLES_PER_US, 12, clk cycles per microsecond; must be at least 4.
NUM_BITS, 32, number of data bits per response, excluding the stop bit.
GLITCH_CYC, 2, low pulses shorter than this many cycles are ignored.
FIRST_TIMEOUT_US, 64, maximum wait from arm to the first falling edge.

Ports:
clk  input  1  system clock
Reset  input  1  asynchronous active-low reset
Data_In  input  1  raw N64 data line, asynchronous, idles high
Enable  input  1  level; high arms and holds a receive, low aborts it
Data_Out  output  NUM_BITS  last complete word; first received bit is in MSB
Valid  output  1  one-cycle pulse when Data_Out updates
Busy  output  1  high while not IDLE
Error  output  1  one-cycle pulse on a framing or timeout failure

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - State goes to IDLE.
  - Data_Out=0, Valid=0, Busy=0, Error=0.
  - Both synchronizer flops preset to 1.
  - Bit counter and cycle counter cleared.
- Reset asserted mid-frame discards the partial word; no Valid or Error is produced.
- Data_In passes through a 2-flop synchronizer. All edge detection uses the synchronized signal, so edges are seen 2 cycles late. Decoded results are unaffected.
- Definitions:
  - LOW_MAX = 4*CYCLES_PER_US.
  - THRESH = 2*CYCLES_PER_US.
  - HIGH_MAX = 8*CYCLES_PER_US.
  - First-edge timeout = FIRST_TIMEOUT_US*CYCLES_PER_US.
- States:
  - IDLE:
    - Busy=0.
    - Enable=1 -> WAIT_FALL, with bit count 0 and cycle counter 0.
  - WAIT_FALL (line high):
    - Cycle counter increments each cycle.
    - Synchronized falling edge -> MEASURE_LOW, cycle counter reset to 1.
    - Counter reaches the first-edge timeout (before any bit) or HIGH_MAX (after at least one bit) -> ERROR.
  - MEASURE_LOW:
    - Count cycles while the line is low.
    - Count reaches LOW_MAX -> ERROR.
    - Rising edge with count < GLITCH_CYC -> back to WAIT_FALL; the pulse is ignored and the high counter continues from its pre-glitch value.
    - Rising edge otherwise: bit = (count < THRESH) ? 1 : 0.
    - If bit count < NUM_BITS: shift the bit into the shift register LSB-in (left shift), increment bit count, go to WAIT_FALL with cycle counter 0.
    - If bit count == NUM_BITS, the pulse is the stop bit:
      - bit==1 -> DONE.
      - bit==0 -> ERROR.
  - DONE:
    - Data_Out <= shift register; Valid=1 for this cycle.
    - Then IDLE if Enable=0, else WAIT_FALL (re-armed, bit count 0).
  - ERROR:
    - Error=1 for one cycle; Data_Out is unchanged.
    - Then IDLE.
- Enable=0 in WAIT_FALL or MEASURE_LOW -> IDLE next cycle; no Valid, no Error. This takes priority over timeouts in the same cycle.
- Both counters saturate; they never wrap.
- Valid and Error are never high in the same cycle.
- Data_Out changes only in DONE.
- Latency: Valid asserts 3 cycles after the raw stop-bit rising edge (2 synchronizer + 1 DONE register).

Test Plan:
- CYCLES_PER_US=4, NUM_BITS=32:
  - Stimulus: send 0x80000001 MSB-first (1 = 4 low/12 high cycles, 0 = 12 low/4 high), then stop bit 4 low.
  - Required: Valid pulses once, Data_Out=0x80000001, Error=0, Busy falls after DONE.
- Stimulus: send all 32 bits as 1, then a stop bit.
  - Required: Data_Out=0xFFFFFFFF.
  - Boundary: a low of exactly 8 cycles decodes as 0; 7 cycles decodes as 1.
- Stimulus: hold the line low for 16 cycles at bit 5.
  - Required: Error pulse at count 16, no Valid, Data_Out keeps its previous value, state IDLE.
- Stimulus: Enable=1 with no traffic.
  - Required: Error after 256 cycles (64 us).
  - Stimulus: a gap greater than 32 high cycles mid-word. Required: Error.
- Stimulus: insert a 1-cycle low glitch between bits 10 and 11.
  - Required: glitch ignored, correct word received, Valid=1.
- Stimulus: deassert Enable at bit 20; separately, assert Reset at bit 20.
  - Required (Enable case): IDLE with no Valid or Error.
  - Required (Reset case): all outputs 0 immediately.
  - Next full frame after either case decodes correctly.

Source files
------------

// File: rtl/n64_bit_receiver_if.sv
// N64 receive-side bundle: raw line and arm in,
// decoded word and status pulses out.
interface n64_bit_receiver_if #(
  parameter int NUM_BITS = 32
);
  logic                Data_In;
  logic                Enable;
  logic [NUM_BITS-1:0] Data_Out;
  logic                Valid;
  logic                Busy;
  logic                Error;

  modport master (
    output Data_In,
    output Enable,
    input  Data_Out,
    input  Valid,
    input  Busy,
    input  Error
  );

  modport slave (
    input  Data_In,
    input  Enable,
    output Data_Out,
    output Valid,
    output Busy,
    output Error
  );
endinterface

// File: rtl/n64_bit_receiver.sv
// N64 controller response decoder: measures each low
// pulse on the synchronized line and assembles a word.
module n64_bit_receiver #(
  parameter int CYCLES_PER_US    = 12,
  parameter int NUM_BITS         = 32,
  parameter int GLITCH_CYC       = 2,
  parameter int FIRST_TIMEOUT_US = 64
) (
  input logic clk,
  input logic Reset,
  n64_bit_receiver_if.slave bus
);

  localparam int LOW_MAX  = 4 * CYCLES_PER_US;
  localparam int THRESH   = 2 * CYCLES_PER_US;
  localparam int HIGH_MAX = 8 * CYCLES_PER_US;
  localparam int FIRST_TO = FIRST_TIMEOUT_US
                          * CYCLES_PER_US;
  localparam int HI_TOP   = (FIRST_TO > HIGH_MAX)
                          ? FIRST_TO : HIGH_MAX;
  localparam int HW = $clog2(HI_TOP + 1);
  localparam int LW = $clog2(LOW_MAX + 1);
  localparam int BW = $clog2(NUM_BITS + 1);

  localparam logic [HW-1:0] FIRST_LIM = HW'(FIRST_TO);
  localparam logic [HW-1:0] HIGH_LIM  = HW'(HIGH_MAX);
  localparam logic [LW-1:0] LOW_LIM   = LW'(LOW_MAX);
  localparam logic [LW-1:0] THR_LIM   = LW'(THRESH);
  localparam logic [LW-1:0] GL_LIM    = LW'(GLITCH_CYC);
  localparam logic [BW-1:0] NB_LIM    = BW'(NUM_BITS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    MEASURE_LOW,
    DONE,
    ERROR
  } state_t;

  state_t state, state_n;

  logic                s1, s2;
  logic [HW-1:0]       hi_cnt, hi_n, hi_inc, hi_lim;
  logic [LW-1:0]       lo_cnt, lo_n, lo_inc;
  logic [BW-1:0]       bit_cnt, bits_n;
  logic [NUM_BITS-1:0] sr, sr_n;
  logic [NUM_BITS-1:0] dout, dout_n;
  logic                din, en, bit_val;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.Data_In;
      s2 <= s1;
    end
  end

  assign din     = s2;
  assign en      = bus.Enable;
  assign bit_val = lo_cnt < THR_LIM;

  // Counters hold at all-ones instead of wrapping.
  assign hi_inc = (hi_cnt == '1) ? hi_cnt
                : hi_cnt + HW'(1);
  assign lo_inc = (lo_cnt == '1) ? lo_cnt
                : lo_cnt + LW'(1);
  assign hi_lim = (bit_cnt == '0) ? FIRST_LIM
                : HIGH_LIM;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      hi_cnt  <= '0;
      lo_cnt  <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      dout    <= '0;
    end else begin
      state   <= state_n;
      hi_cnt  <= hi_n;
      lo_cnt  <= lo_n;
      bit_cnt <= bits_n;
      sr      <= sr_n;
      dout    <= dout_n;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi_cnt;
    lo_n    = lo_cnt;
    bits_n  = bit_cnt;
    sr_n    = sr;
    dout_n  = dout;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = WAIT_FALL;
          hi_n    = '0;
          lo_n    = '0;
          bits_n  = '0;
        end
      end
      WAIT_FALL: begin
        if (!en) begin
          state_n = IDLE;
        end else if (!din) begin
          state_n = MEASURE_LOW;
          lo_n    = LW'(1);
        end else begin
          hi_n = hi_inc;
          if (hi_inc >= hi_lim) state_n = ERROR;
        end
      end
      MEASURE_LOW: begin
        if (!en) begin
          state_n = IDLE;
        end else if (!din) begin
          lo_n = lo_inc;
          if (lo_inc >= LOW_LIM) state_n = ERROR;
        end else if (lo_cnt < GL_LIM) begin
          // Glitch: resume the high gap where it left off.
          state_n = WAIT_FALL;
        end else if (bit_cnt < NB_LIM) begin
          sr_n    = {sr[NUM_BITS-2:0], bit_val};
          bits_n  = bit_cnt + BW'(1);
          hi_n    = '0;
          state_n = WAIT_FALL;
        end else if (bit_val) begin
          dout_n  = sr;
          state_n = DONE;
        end else begin
          state_n = ERROR;
        end
      end
      DONE: begin
        if (en) begin
          state_n = WAIT_FALL;
          hi_n    = '0;
          lo_n    = '0;
          bits_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      ERROR: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.Data_Out = dout;
  assign bus.Valid    = (state == DONE);
  assign bus.Error    = (state == ERROR);
  assign bus.Busy     = (state != IDLE);

endmodule

// File: tb/tb_n64_bit_receiver.sv
// Directed bench for n64_bit_receiver at 4 cycles/us:
// frames, pulse-width boundaries, timeouts, aborts.
module tb_n64_bit_receiver;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  n64_bit_receiver_if #(.NUM_BITS(32)) bus ();

  n64_bit_receiver #(
    .CYCLES_PER_US    (4),
    .NUM_BITS         (32),
    .GLITCH_CYC       (2),
    .FIRST_TIMEOUT_US (64)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int v_cnt  = 0;
  int e_cnt  = 0;
  int both   = 0;
  int v0, e0;

  always @(negedge clk) begin
    if (bus.Valid) v_cnt <= v_cnt + 1;
    if (bus.Error) e_cnt <= e_cnt + 1;
    if (bus.Valid && bus.Error) both <= both + 1;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_low(input int n);
    bus.Data_In = 1'b0;
    tick(n);
  endtask

  task automatic send_high(input int n);
    bus.Data_In = 1'b1;
    tick(n);
  endtask

  task automatic send_pulse(input int lo, input int hi);
    send_low(lo);
    send_high(hi);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(4, 12);
    else   send_pulse(12, 4);
  endtask

  task automatic send_bits(input logic [31:0] w,
                           input int n,
                           input int g);
    for (int i = 31; i > 31 - n; i--) begin
      send_bit(w[i]);
      if (i == g) send_pulse(1, 3);
    end
  endtask

  task automatic send_frame(input logic [31:0] w,
                            input int g);
    send_bits(w, 32, g);
    send_pulse(4, 8);
  endtask

  task automatic snap();
    v0 = v_cnt;
    e0 = e_cnt;
  endtask

  task automatic disarm();
    bus.Enable  = 1'b0;
    bus.Data_In = 1'b1;
    tick(3);
  endtask

  initial begin
    Reset       = 1'b0;
    bus.Enable  = 1'b0;
    bus.Data_In = 1'b1;
    tick(3);
    check("rst_data", 64'(bus.Data_Out), 64'h0);
    check("rst_valid", 64'(bus.Valid), 64'h0);
    check("rst_busy", 64'(bus.Busy), 64'h0);
    check("rst_error", 64'(bus.Error), 64'h0);
    Reset = 1'b1;
    tick(2);

    // Frame 0x80000001 with exact Valid latency
    snap();
    bus.Enable = 1'b1;
    tick(2);
    check("arm_busy", 64'(bus.Busy), 64'h1);
    send_bits(32'h8000_0001, 32, -1);
    send_low(4);
    bus.Data_In = 1'b1;
    tick(2);
    check("lat_early", 64'(bus.Valid), 64'h0);
    tick(1);
    check("lat_valid", 64'(bus.Valid), 64'h1);
    check("f1_data", 64'(bus.Data_Out),
          64'h8000_0001);
    tick(5);
    check("f1_vcnt", 64'(v_cnt - v0), 64'h1);
    check("f1_ecnt", 64'(e_cnt - e0), 64'h0);
    disarm();
    check("f1_busy", 64'(bus.Busy), 64'h0);

    // All ones
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_frame(32'hFFFF_FFFF, -1);
    check("ones_data", 64'(bus.Data_Out),
          64'hFFFF_FFFF);
    check("ones_vcnt", 64'(v_cnt - v0), 64'h1);
    disarm();

    // Low widths 8 -> 0, 7 -> 1, 15 -> 0
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_pulse(8, 8);
    send_pulse(7, 9);
    send_pulse(15, 4);
    for (int i = 0; i < 29; i++) send_bit(1'b1);
    send_pulse(4, 8);
    check("bnd_data", 64'(bus.Data_Out),
          64'h5FFF_FFFF);
    check("bnd_vcnt", 64'(v_cnt - v0), 64'h1);
    check("bnd_ecnt", 64'(e_cnt - e0), 64'h0);
    disarm();

    // Line stuck low at bit 5
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_bits(32'hFFFF_FFFF, 5, -1);
    bus.Data_In = 1'b0;
    tick(17);
    check("low_early", 64'(bus.Error), 64'h0);
    tick(1);
    check("low_err", 64'(bus.Error), 64'h1);
    check("low_novalid", 64'(bus.Valid), 64'h0);
    disarm();
    check("low_busy", 64'(bus.Busy), 64'h0);
    check("low_keep", 64'(bus.Data_Out),
          64'h5FFF_FFFF);
    check("low_vcnt", 64'(v_cnt - v0), 64'h0);
    check("low_ecnt", 64'(e_cnt - e0), 64'h1);

    // No traffic after arm
    snap();
    bus.Enable = 1'b1;
    tick(256);
    check("to_early", 64'(bus.Error), 64'h0);
    tick(1);
    check("to_err", 64'(bus.Error), 64'h1);
    disarm();
    check("to_ecnt", 64'(e_cnt - e0), 64'h1);

    // Mid-word high gap
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_bits(32'hFFFF_FFFF, 3, -1);
    send_high(40);
    check("gap_ecnt", 64'(e_cnt - e0), 64'h1);
    check("gap_vcnt", 64'(v_cnt - v0), 64'h0);
    disarm();

    // 1-cycle glitch between bits 10 and 11
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_frame(32'hA5C3_0F96, 21);
    check("gl_data", 64'(bus.Data_Out),
          64'hA5C3_0F96);
    check("gl_vcnt", 64'(v_cnt - v0), 64'h1);
    check("gl_ecnt", 64'(e_cnt - e0), 64'h0);
    disarm();

    // Enable dropped at bit 20, then a full frame
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_bits(32'h1234_5678, 20, -1);
    bus.Enable = 1'b0;
    tick(2);
    check("ab_busy", 64'(bus.Busy), 64'h0);
    tick(3);
    check("ab_vcnt", 64'(v_cnt - v0), 64'h0);
    check("ab_ecnt", 64'(e_cnt - e0), 64'h0);
    snap();
    bus.Enable = 1'b1;
    tick(2);
    send_frame(32'h1234_5678, -1);
    check("ab_data", 64'(bus.Data_Out),
          64'h1234_5678);
    check("ab_next", 64'(v_cnt - v0), 64'h1);
    disarm();

    // Reset at bit 20, then a full frame
    bus.Enable = 1'b1;
    tick(2);
    send_bits(32'hDEAD_BEEF, 20, -1);
    bus.Data_In = 1'b0;
    tick(2);
    Reset = 1'b0;
    #1;
    check("mr_data", 64'(bus.Data_Out), 64'h0);
    check("mr_busy", 64'(bus.Busy), 64'h0);
    check("mr_valid", 64'(bus.Valid), 64'h0);
    check("mr_error", 64'(bus.Error), 64'h0);
    tick(2);
    bus.Data_In = 1'b1;
    Reset = 1'b1;
    snap();
    tick(2);
    send_frame(32'hDEAD_BEEF, -1);
    check("mr_next", 64'(bus.Data_Out),
          64'hDEAD_BEEF);
    check("mr_vcnt", 64'(v_cnt - v0), 64'h1);
    check("mr_ecnt", 64'(e_cnt - e0), 64'h0);
    disarm();

    check("excl", 64'(both), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
